// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between a register master and axi4_lite_reg_slave.
//   AW: AWADDR[3:0], AWVALID, AWREADY
//   W : WDATA[31:0], WVALID, WREADY
//   B : BRESP[1:0], BVALID, BREADY
//   AR: ARADDR[3:0], ARVALID, ARREADY
//   R : RDATA[31:0], RRESP[1:0], RVALID, RREADY
// The clock and reset are not part of the bundle; they stay plain ports.
interface axi4_lite_reg_slave_if;
    logic [3:0]  AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    modport slave (
        input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register responder: four 32-bit registers at byte offsets
// 0x0/0x4/0x8/0xC (address bits [1:0] ignored).
// Ports:
//   ACLK    - clock, all logic on rising edge
//   ARESETn - asynchronous active-low reset
//   axi     - axi4_lite_reg_slave_if.slave bus bundle (AW/W/B/AR/R)
// Parameter:
//   REG_RST - reset value of every register
// Optional build macro AXIL_SLV_WCNT_EN: reg3 becomes a read-only counter of
// committed writes; writes to 0xC answer SLVERR and change nothing.
//
// Write FSM
//   state   | meaning
//   WR_IDLE | collecting AW and W (either order); commit when both present
//   WR_RESP | write committed, BVALID held until BREADY
// Read FSM
//   state   | meaning
//   RD_IDLE | ARREADY high, waiting for an address
//   RD_DATA | RVALID held with captured data until RREADY
module axi4_lite_reg_slave #(
    parameter logic [31:0] REG_RST = 32'h0000_0000
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    axi4_lite_reg_slave_if.slave axi
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
`ifdef AXIL_SLV_WCNT_EN
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         NREG        = 3;
`else
    localparam int         NREG        = 4;
`endif

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic                   aw_full_q, aw_full_d;
    logic                   w_full_q, w_full_d;
    logic [1:0]             aw_idx_q, aw_idx_d;
    logic [31:0]            w_data_q, w_data_d;
    logic                   bvalid_q, bvalid_d;
    logic [1:0]             bresp_q, bresp_d;
    logic [NREG-1:0][31:0]  regs_q, regs_d;
    logic                   rvalid_q, rvalid_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;
`ifdef AXIL_SLV_WCNT_EN
    logic [31:0]            wcnt_q, wcnt_d;
`endif

    logic                   aw_hs, w_hs, ar_hs;
    logic [1:0]             commit_idx;
    logic [31:0]            commit_data;
    logic [3:0][31:0]       rd_view;

    // Byte-lane bits are not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi.AWADDR[1:0], axi.ARADDR[1:0]};

    assign axi.AWREADY = ~aw_full_q & ~bvalid_q;
    assign axi.WREADY  = ~w_full_q & ~bvalid_q;
    assign axi.BVALID  = bvalid_q;
    assign axi.BRESP   = bresp_q;
    assign axi.ARREADY = ~rvalid_q;
    assign axi.RVALID  = rvalid_q;
    assign axi.RDATA   = rdata_q;
    assign axi.RRESP   = rresp_q;

    assign aw_hs = axi.AWVALID & ~aw_full_q & ~bvalid_q;
    assign w_hs  = axi.WVALID & ~w_full_q & ~bvalid_q;
    assign ar_hs = axi.ARVALID & ~rvalid_q;

    // A handshake happening this edge takes priority over the held copy, so
    // the commit can use whichever half arrives last without a wait cycle.
    assign commit_idx  = aw_hs ? axi.AWADDR[3:2] : aw_idx_q;
    assign commit_data = w_hs ? axi.WDATA : w_data_q;

`ifdef AXIL_SLV_WCNT_EN
    assign rd_view = {wcnt_q, regs_q};
`else
    assign rd_view = regs_q;
`endif

    // Write path
    always_comb begin
        wr_state_d = wr_state_q;
        aw_full_d  = aw_full_q;
        w_full_d   = w_full_q;
        aw_idx_d   = aw_idx_q;
        w_data_d   = w_data_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
`ifdef AXIL_SLV_WCNT_EN
        wcnt_d     = wcnt_q;
`endif

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = axi.AWADDR[3:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = axi.WDATA;
        end

        unique case (wr_state_q)
            WR_IDLE: begin
                if ((aw_full_q | aw_hs) && (w_full_q | w_hs)) begin
                    bvalid_d   = 1'b1;
                    bresp_d    = RESP_OKAY;
                    wr_state_d = WR_RESP;
`ifdef AXIL_SLV_WCNT_EN
                    if (commit_idx == 2'd3) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        regs_d[commit_idx] = commit_data;
                        wcnt_d             = wcnt_q + 32'd1;
                    end
`else
                    regs_d[commit_idx] = commit_data;
`endif
                end
            end
            WR_RESP: begin
                // Flags stay set through the response so no new AW/W is taken.
                if (axi.BREADY) begin
                    bvalid_d   = 1'b0;
                    aw_full_d  = 1'b0;
                    w_full_d   = 1'b0;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Read path; rd_view is the pre-edge register state, so a same-edge
    // write to the addressed register returns the old value.
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        unique case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rdata_d    = rd_view[axi.ARADDR[3:2]];
                    rresp_d    = RESP_OKAY;
                    rvalid_d   = 1'b1;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi.RREADY) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state_q <= WR_IDLE;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            aw_idx_q   <= 2'd0;
            w_data_q   <= 32'd0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            regs_q     <= {NREG{REG_RST}};
            rd_state_q <= RD_IDLE;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'd0;
            rresp_q    <= RESP_OKAY;
`ifdef AXIL_SLV_WCNT_EN
            wcnt_q     <= 32'd0;
`endif
        end else begin
            wr_state_q <= wr_state_d;
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            aw_idx_q   <= aw_idx_d;
            w_data_q   <= w_data_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            regs_q     <= regs_d;
            rd_state_q <= rd_state_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
`ifdef AXIL_SLV_WCNT_EN
            wcnt_q     <= wcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
module tb_axi4_lite_reg_slave;

    localparam logic [31:0] RST_VAL = 32'h1234_5678;
`ifdef AXIL_SLV_WCNT_EN
    localparam bit WCNT = 1'b1;
`else
    localparam bit WCNT = 1'b0;
`endif

    logic clk_sys;
    logic rst_b;
    int   n_chk;
    int   n_fail;

    axi4_lite_reg_slave_if bus ();

    axi4_lite_reg_slave #(.REG_RST(RST_VAL)) dut (
        .ACLK    (clk_sys),
        .ARESETn (rst_b),
        .axi     (bus.slave)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Reference model: register contents and committed-write count.
    logic [31:0] m_regs [4];
    logic [31:0] m_cnt;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = RST_VAL;
        m_cnt = 32'd0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] idx);
        if (WCNT && idx == 2'd3) return m_cnt;
        return m_regs[idx];
    endfunction

    // Applies a write to the model; returns the expected BRESP.
    function automatic logic [1:0] model_write(input logic [1:0] idx, input logic [31:0] data);
        if (WCNT && idx == 2'd3) return 2'b10;
        m_regs[idx] = data;
        m_cnt = m_cnt + 32'd1;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Full write; W/AW start after their own delays; BREADY held low for
    // hold cycles while a stray AW/W is offered that must not be taken.
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input int aw_dly, input int w_dly, input int hold,
                            input bit complete);
        bit aw_done = 0, w_done = 0, aw_now, w_now;
        int cyc = 0;
        logic [1:0] exp_resp;
        bus.BREADY = 1'b0;
        while (!(aw_done && w_done) && cyc < 20) begin
            bus.AWADDR  = addr;
            bus.AWVALID = !aw_done && cyc >= aw_dly;
            bus.WDATA   = data;
            bus.WVALID  = !w_done && cyc >= w_dly;
            #1;
            if (w_done) chk("wready_low_after_w", 32'(bus.WREADY), 32'd0);
            if (aw_done) chk("awready_low_after_aw", 32'(bus.AWREADY), 32'd0);
            chk("bvalid_before_commit", 32'(bus.BVALID), 32'd0);
            aw_now = bus.AWVALID && bus.AWREADY;
            w_now  = bus.WVALID && bus.WREADY;
            tick();
            if (aw_now) aw_done = 1;
            if (w_now) w_done = 1;
            cyc++;
        end
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        if (!(aw_done && w_done)) begin
            chk("write_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        exp_resp = model_write(addr[3:2], data);
        chk("bvalid_after_commit", 32'(bus.BVALID), 32'd1);
        chk("bresp", 32'(bus.BRESP), 32'(exp_resp));
        for (int i = 0; i < hold; i++) begin
            bus.AWADDR  = addr ^ 4'hC;
            bus.AWVALID = 1'b1;
            bus.WDATA   = ~data;
            bus.WVALID  = 1'b1;
            #1;
            chk("awready_during_b", 32'(bus.AWREADY), 32'd0);
            chk("wready_during_b", 32'(bus.WREADY), 32'd0);
            tick();
            chk("bvalid_hold", 32'(bus.BVALID), 32'd1);
            chk("bresp_hold", 32'(bus.BRESP), 32'(exp_resp));
        end
        if (!complete) begin
            bus.AWVALID = 1'b0;
            bus.WVALID  = 1'b0;
            return;
        end
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY  = 1'b0;
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        chk("bvalid_cleared", 32'(bus.BVALID), 32'd0);
        chk("awready_after_b", 32'(bus.AWREADY), 32'd1);
    endtask

    task automatic do_read(input logic [3:0] addr, input int hold);
        logic [31:0] exp = model_read(addr[3:2]);
        bus.ARADDR  = addr;
        bus.ARVALID = 1'b1;
        bus.RREADY  = 1'b0;
        #1;
        chk("arready_idle", 32'(bus.ARREADY), 32'd1);
        tick();
        bus.ARVALID = 1'b0;
        chk("rvalid", 32'(bus.RVALID), 32'd1);
        chk("rdata", bus.RDATA, exp);
        chk("rresp", 32'(bus.RRESP), 32'd0);
        for (int i = 0; i < hold; i++) begin
            bus.ARVALID = 1'b1;
            bus.ARADDR  = addr ^ 4'h4;
            tick();
            chk("arready_hold", 32'(bus.ARREADY), 32'd0);
            chk("rvalid_hold", 32'(bus.RVALID), 32'd1);
            chk("rdata_hold", bus.RDATA, exp);
        end
        bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b1;
        tick();
        bus.RREADY = 1'b0;
        chk("rvalid_cleared", 32'(bus.RVALID), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old0;
        n_chk  = 0;
        n_fail = 0;
        bus.AWADDR = '0; bus.AWVALID = 0; bus.WDATA = '0; bus.WVALID = 0;
        bus.BREADY = 0; bus.ARADDR = '0; bus.ARVALID = 0; bus.RREADY = 0;
        rst_b = 1'b0;
        model_reset();
        #22 rst_b = 1'b1;
        tick();
        chk("rst_awready", 32'(bus.AWREADY), 32'd1);
        chk("rst_wready", 32'(bus.WREADY), 32'd1);
        chk("rst_arready", 32'(bus.ARREADY), 32'd1);
        chk("rst_bvalid", 32'(bus.BVALID), 32'd0);
        chk("rst_rvalid", 32'(bus.RVALID), 32'd0);
        chk("rst_rdata", bus.RDATA, 32'd0);
        for (int i = 0; i < 4; i++) do_read(4'(i * 4), 0);

        // Sequential writes 1..4, then read back.
        for (int i = 0; i < 4; i++) do_write(4'(i * 4), 32'(i + 1), 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) do_read(4'(i * 4), 0);

        // W leads AW by three cycles.
        do_write(4'h8, 32'hDEAD_BEEF, 3, 0, 0, 1);
        do_read(4'h8, 0);
        // AW leads W.
        do_write(4'h4, 32'h0000_0002, 0, 2, 0, 1);

        // BREADY held low five cycles with a second AW/W pending.
        do_write(4'h1, 32'hA0A0_0001, 1, 1, 5, 1);
        do_read(4'h4, 4);
        for (int i = 0; i < 4; i++) do_read(4'(i * 4), 0);

        // Same-edge write and read of reg0.
        old0 = model_read(2'd0);
        bus.AWADDR = 4'h0; bus.AWVALID = 1; bus.WDATA = 32'h55; bus.WVALID = 1;
        bus.ARADDR = 4'h0; bus.ARVALID = 1;
        #1;
        chk("same_edge_readies", 32'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 32'h7);
        tick();
        bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0;
        chk("same_edge_bresp", 32'(bus.BRESP), 32'(model_write(2'd0, 32'h55)));
        chk("same_edge_bvalid", 32'(bus.BVALID), 32'd1);
        chk("same_edge_rvalid", 32'(bus.RVALID), 32'd1);
        chk("same_edge_old_data", bus.RDATA, old0);
        bus.BREADY = 1; bus.RREADY = 1;
        tick();
        bus.BREADY = 0; bus.RREADY = 0;
        chk("same_edge_done", 32'({bus.BVALID, bus.RVALID}), 32'd0);
        do_read(4'h0, 0);

        // Randomized mix against the model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(1, 0) == 1)
                do_write(4'($urandom_range(15, 0)), $urandom,
                         $urandom_range(3, 0), $urandom_range(3, 0),
                         $urandom_range(2, 0), 1);
            else
                do_read(4'($urandom_range(15, 0)), $urandom_range(2, 0));
        end
        for (int i = 0; i < 4; i++) do_read(4'(i * 4), 0);

        // Reset asserted while BVALID is high; also a read in flight.
        do_write(4'h8, 32'hCAFE_F00D, 0, 0, 1, 0);
        bus.ARADDR = 4'h4; bus.ARVALID = 1;
        tick();
        bus.ARVALID = 0;
        chk("pre_reset_bvalid", 32'(bus.BVALID), 32'd1);
        chk("pre_reset_rvalid", 32'(bus.RVALID), 32'd1);
        #2 rst_b = 1'b0;
        #1;
        chk("async_rst_bvalid", 32'(bus.BVALID), 32'd0);
        chk("async_rst_rvalid", 32'(bus.RVALID), 32'd0);
        model_reset();
        #13 rst_b = 1'b1;
        tick();
        chk("post_rst_readies", 32'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 32'h7);

        // Partial AW captured, then reset: nothing must be written.
        bus.AWADDR = 4'h0; bus.AWVALID = 1;
        tick();
        bus.AWVALID = 0;
        chk("partial_aw_held", 32'(bus.AWREADY), 32'd0);
        #3 rst_b = 1'b0;
        #10 rst_b = 1'b1;
        tick();
        bus.WDATA = 32'hBAD0_BAD0; bus.WVALID = 1;
        tick();
        bus.WVALID = 0;
        tick();
        chk("no_commit_after_partial", 32'(bus.BVALID), 32'd0);
        chk("wready_after_partial_w", 32'(bus.WREADY), 32'd0);
        for (int i = 0; i < 4; i++) do_read(4'(i * 4), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_reg_slave.md
# axi4_lite_reg_slave

AXI4-Lite responder (slave end) exposing four 32-bit registers on a 4-bit byte address space. Accepts write address and write data in either order, commits the write, and returns a write response; serves single-beat reads independently of writes. Sits on the AXI4-Lite bus opposite `AXI4_Lite_Master` as the register target for bus bring-up and peripheral control.

## Interface
- `REG_RST`, 32'h0000_0000, reset value of every register
- `ACLK` in 1 — single clock, all logic on rising edge
- `ARESETn` in 1 — asynchronous, active-low reset
- `AWADDR` in 4 — write byte address; bits [3:2] select register
- `AWVALID` in 1 / `AWREADY` out 1 — AW channel handshake
- `WDATA` in 32 — write data
- `WVALID` in 1 / `WREADY` out 1 — W channel handshake
- `BRESP` out 2 — write response
- `BVALID` out 1 / `BREADY` in 1 — B channel handshake
- `ARADDR` in 4 — read byte address; bits [3:2] select register
- `ARVALID` in 1 / `ARREADY` out 1 — AR channel handshake
- `RDATA` out 32 — read data
- `RRESP` out 2 — read response
- `RVALID` out 1 / `RREADY` in 1 — R channel handshake

## Operation
- Address bits [1:0] ignored; no alignment error. Registers reg0..reg3 at 0x0/0x4/0x8/0xC.
- Write path: flags `aw_full`, `w_full`, state `WR_IDLE`/`WR_RESP`.
  - `AWREADY = ~aw_full & ~BVALID`; `WREADY = ~w_full & ~BVALID` (from registered state).
  - AW handshake latches `AWADDR[3:2]`, sets `aw_full`; W handshake latches `WDATA`, sets `w_full`. Either order, or same edge.
  - On the edge where both are complete (held or handshaking now): register written, `BVALID`←1, `BRESP`←2'b00, state→`WR_RESP`.
  - `WR_RESP`: `BVALID`, `BRESP` stable until `BREADY`; on B handshake edge `BVALID`←0, both flags cleared, state→`WR_IDLE`.
  - No second AW or W accepted until the B handshake completes (one outstanding write).
- Read path: state `RD_IDLE`/`RD_DATA`.
  - `ARREADY = ~RVALID`.
  - AR handshake: `RDATA`←reg[`ARADDR[3:2]`], `RRESP`←2'b00, `RVALID`←1, state→`RD_DATA`.
  - `RDATA`/`RRESP` stable until `RREADY`; on R handshake `RVALID`←0, state→`RD_IDLE`.
- Read and write paths fully independent; may complete on the same edge.
- Same-edge read capture and write commit to the same register: `RDATA` returns the old value.

## Timing
- Reset (async assert, any cycle): all registers←`REG_RST`; `BVALID`, `RVALID`←0; `BRESP`, `RRESP`←2'b00; `RDATA`←0; flags cleared; states IDLE. `AWREADY`, `WREADY`, `ARREADY` read 1 immediately after deassertion (no pending state).
- Reset mid-transaction: partial AW/W capture and pending B/R discarded; no register write for an uncommitted transaction.
- Write latency: `BVALID` high in the cycle after the later of the AW/W handshakes. Register value visible to a read whose AR handshakes on or after the cycle `BVALID` rises.
- Read latency: `RVALID` high in the cycle after the AR handshake.
- With `BREADY`/`RREADY` held high: one write per 2 cycles, one read per 2 cycles.
- VALID held without READY never drops any data; master VALID deassertion before handshake causes no state change.

## Configuration
- `AXIL_SLV_WCNT_EN` defined: reg3 (0xC) is a read-only 32-bit counter of committed writes, reset 0, incremented on each register-write commit, wraps 32'hFFFF_FFFF→0. Write to 0xC: register unchanged, counter not incremented, `BRESP`=2'b10 (SLVERR); B handshake timing unchanged.
- Undefined: reg3 is an ordinary read/write register like reg0..reg2; all `BRESP`=2'b00.

## Test plan
- Reset then sequential writes 1,2,3,4 to 0x0,0x4,0x8,0xC with `BREADY`=1 -> each `BVALID` one cycle after handshake, `BRESP`=00; reads of 0x0..0xC return 1,2,3,4 (macro on: 0xC returns 3, write to 0xC gets `BRESP`=10).
- W presented 3 cycles before AW (data 32'hDEAD_BEEF, addr 0x8) -> `WREADY` drops after W handshake, `BVALID` one cycle after AW handshake, read 0x8 = 32'hDEAD_BEEF.
- `BREADY` held low 5 cycles after write -> `BVALID` stays high, `AWREADY`/`WREADY` stay low, second AW not accepted until B handshake.
- `RREADY` low 4 cycles after read of 0x4 -> `RVALID`, `RDATA`=2 stable, `ARREADY`=0 throughout.
- Same-edge write 32'h55 to 0x0 and read of 0x0 (old value 1) -> `RDATA`=1; next read returns 32'h55.
- Assert `ARESETn` low while `BVALID`=1 -> `BVALID`=0 immediately, all registers read `REG_RST` after release.
